// File: rtl/expression_y_unpacker_if.sv
// Handshake bundle between an expression_* producer, the y unpacker and its field sink.
// master drives the packed word and field ready; slave is the unpacker itself.
interface expression_y_unpacker_if #(
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic [89:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_last;
  logic [OUT_W-1:0] sig;
  logic             sig_valid;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, sig, sig_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, sig, sig_valid
  );
endinterface

// File: rtl/expression_y_unpacker.sv
// Splits the 90-bit y = {y0..y17} word into 18 extended, index-tagged fields, one per handshake.
// Optional XOR signature of each word's fields is built when EXPR_UNPACK_SIG_EN is defined.
module expression_y_unpacker #(
  parameter int OUT_W     = 8,
  parameter int SIGN_EXT  = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  expression_y_unpacker_if.slave   bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [4:0] FIRST_IDX = (MSB_FIRST != 0) ? 5'd0  : 5'd17;
  localparam logic [4:0] LAST_IDX  = (MSB_FIRST != 0) ? 5'd17 : 5'd0;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [89:0] word_q, word_d;

  logic             in_ready_w, accept_w, fire_w, last_w;
  logic [4:0]       grp, sub, off;
  logic [2:0]       wid;
  logic [6:0]       lsb;
  logic [5:0]       raw;
  logic             is_signed;
  logic [OUT_W-1:0] lo_mask, ext;

  // Ready is held low for as long as reset is asserted, not just until the next edge.
  assign in_ready_w = (state_q == IDLE) && !rst;
  assign accept_w   = in_ready_w && bus.in_valid;
  assign last_w     = (state_q == EMIT) && (idx_q == LAST_IDX);
  assign fire_w     = (state_q == EMIT) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          word_d  = bus.in_data;
          idx_d   = FIRST_IDX;
          state_d = EMIT;
        end
      end
      default: begin
        if (bus.out_ready) begin
          if (last_w) begin
            state_d = IDLE;
          end else if (MSB_FIRST != 0) begin
            idx_d = idx_q + 5'd1;
          end else begin
            idx_d = idx_q - 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  // Each 30-bit group holds widths 4,5,6,4,5,6; the last three are signed.
  always_comb begin
    grp = idx_q / 5'd6;
    sub = idx_q % 5'd6;
    off = 5'd0;
    wid = 3'd4;
    case (sub)
      5'd0:    begin off = 5'd0;  wid = 3'd4; end
      5'd1:    begin off = 5'd4;  wid = 3'd5; end
      5'd2:    begin off = 5'd9;  wid = 3'd6; end
      5'd3:    begin off = 5'd15; wid = 3'd4; end
      5'd4:    begin off = 5'd19; wid = 3'd5; end
      default: begin off = 5'd24; wid = 3'd6; end
    endcase
    lsb       = 7'd90 - 7'(grp) * 7'd30 - 7'(off) - 7'(wid);
    raw       = 6'(word_q >> lsb) & ((6'd1 << wid) - 6'd1);
    is_signed = (sub >= 5'd3);
    lo_mask   = (OUT_W'(1) << wid) - OUT_W'(1);
    ext       = OUT_W'(raw);
    if ((SIGN_EXT != 0) && is_signed && raw[wid - 3'd1]) begin
      ext = ext | ~lo_mask;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = (state_q == EMIT) ? ext : '0;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_w;

`ifdef EXPR_UNPACK_SIG_EN
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic             sig_vld_q, sig_vld_d;

  always_comb begin
    acc_d     = acc_q;
    sig_d     = sig_q;
    sig_vld_d = 1'b0;
    if (accept_w) begin
      acc_d = '0;
    end else if (fire_w) begin
      acc_d = acc_q ^ bus.out_data;
      if (last_w) begin
        sig_d     = acc_q ^ bus.out_data;
        sig_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      sig_q     <= '0;
      sig_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sig_q     <= sig_d;
      sig_vld_q <= sig_vld_d;
    end
  end

  assign bus.sig       = sig_q;
  assign bus.sig_valid = sig_vld_q;
`else
  assign bus.sig       = '0;
  assign bus.sig_valid = 1'b0;
`endif

endmodule

// File: tb/tb_expression_y_unpacker.sv
// Drives three unpacker configurations with one shared stimulus stream and checks every field
// against a field-layout model computed directly from widths and offsets.
module tb_expression_y_unpacker;

`ifdef EXPR_UNPACK_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [89:0] in_data;
  logic        out_ready;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  expression_y_unpacker_if #(.OUT_W(8)) ifa ();
  expression_y_unpacker_if #(.OUT_W(8)) ifb ();
  expression_y_unpacker_if #(.OUT_W(8)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.in_data = in_data;  assign ifc.out_ready = out_ready;

  expression_y_unpacker #(.OUT_W(8), .SIGN_EXT(1), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  expression_y_unpacker #(.OUT_W(8), .SIGN_EXT(1), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  expression_y_unpacker #(.OUT_W(8), .SIGN_EXT(0), .MSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  bit          sext_p [3] = '{1'b1, 1'b1, 1'b0};
  bit          msbf_p [3] = '{1'b1, 1'b0, 1'b1};
  logic        ov [3];
  logic [7:0]  od [3];
  logic [4:0]  oi [3];
  logic        ol [3];
  logic        ir [3];
  logic [7:0]  sg [3];
  logic        sv [3];

  assign ov[0] = ifa.out_valid; assign od[0] = ifa.out_data; assign oi[0] = ifa.out_idx;
  assign ol[0] = ifa.out_last;  assign ir[0] = ifa.in_ready; assign sg[0] = ifa.sig; assign sv[0] = ifa.sig_valid;
  assign ov[1] = ifb.out_valid; assign od[1] = ifb.out_data; assign oi[1] = ifb.out_idx;
  assign ol[1] = ifb.out_last;  assign ir[1] = ifb.in_ready; assign sg[1] = ifb.sig; assign sv[1] = ifb.sig_valid;
  assign ov[2] = ifc.out_valid; assign od[2] = ifc.out_data; assign oi[2] = ifc.out_idx;
  assign ol[2] = ifc.out_last;  assign ir[2] = ifc.in_ready; assign sg[2] = ifc.sig; assign sv[2] = ifc.sig_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Field i of word w, extended to 8 bits, straight from the group/width layout.
  function automatic logic [7:0] fld(input logic [89:0] w, input int i, input bit sext);
    int g, m, wd, pos, v;
    g   = i / 6;
    m   = i % 6;
    wd  = 4 + (m % 3);
    pos = 89 - 30 * g;
    for (int j = 0; j < m; j++) pos -= 4 + (j % 3);
    v = int'((w >> (pos - wd + 1)) & ((90'd1 << wd) - 90'd1));
    if (sext && m >= 3 && v >= (1 << (wd - 1))) v = v - (1 << wd) + 256;
    return v[7:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int n = 0; n < 3; n++) begin
      chk({tag, "_out_valid"}, ov[n], 0);
      chk({tag, "_out_data"},  od[n], 0);
      chk({tag, "_out_idx"},   oi[n], 0);
      chk({tag, "_out_last"},  ol[n], 0);
      chk({tag, "_in_ready"},  ir[n], 0);
      chk({tag, "_sig"},       sg[n], 0);
      chk({tag, "_sig_valid"}, sv[n], 0);
    end
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  // abort_at < 18 asserts reset once that many fields have been taken.
  task automatic run_word(input logic [89:0] d, input int mode, input bit hold, input int abort_at);
    logic [7:0] acc [3];
    logic [7:0] sig_exp [3];
    int k, cyc, to, ix;
    in_data  = d;
    in_valid = 1'b1;
    to = 0;
    while (!ir[0] && to < 100) begin @(posedge clk); #1; to++; end
    chk("accept_wait", (to < 100), 1);
    @(posedge clk); #1;
    if (hold) in_data = ~d;
    else in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      acc[n] = 8'h00;
      chk("first_field_latency", ov[n], 1);
      chk("busy_in_ready", ir[n], 0);
    end
    k = 0; cyc = 0;
    while (k < 18 && cyc < 300) begin
      if (k == abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) chk("abort_release_in_ready", ir[n], 1);
        @(negedge clk);
        for (int n = 0; n < 3; n++) chk("abort_no_sig_pulse", sv[n], 0);
        @(posedge clk); #1;
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
        ix = msbf_p[n] ? k : 17 - k;
        chk("field_valid", ov[n], 1);
        chk("field_idx",   oi[n], ix);
        chk("field_data",  od[n], fld(d, ix, sext_p[n]));
        chk("field_last",  ol[n], (k == 17));
        if (out_ready) acc[n] = acc[n] ^ fld(d, ix, sext_p[n]);
      end
      if (out_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fields_per_word", k, 18);
    if (mode == 0) chk("cycles_per_word", cyc, 18);
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      sig_exp[n] = SIG_EN ? acc[n] : 8'h00;
      chk("done_in_ready",  ir[n], 1);
      chk("done_out_valid", ov[n], 0);
      chk("sig_valid_pulse", sv[n], SIG_EN);
      chk("sig_value", sg[n], sig_exp[n]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk("sig_valid_drop", sv[n], 0);
      chk("sig_hold", sg[n], sig_exp[n]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [89:0] w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) chk("reset_release_in_ready", ir[n], 1);
    @(posedge clk); #1;

    // all-ones word, full-speed sink
    run_word({90{1'b1}}, 0, 1'b0, 99);
    // only y3 = 4'b1000
    w = 90'd8 << 71;
    run_word(w, 0, 1'b0, 99);
    // y0 = 5, y17 = 6'h21
    w = (90'd5 << 86) | 90'h21;
    run_word(w, 0, 1'b0, 99);
    // stalls with in_valid held high and changing data during emission
    for (int r = 0; r < 2; r++) begin
      w = {26'($urandom), $urandom, $urandom};
      run_word(w, 1, 1'b1, 99);
    end
    // reset mid-word, then a clean word restarting at the first index
    run_word({90{1'b1}}, 0, 1'b0, 7);
    w = {26'($urandom), $urandom, $urandom};
    run_word(w, 0, 1'b0, 99);
    // random data with random backpressure
    for (int r = 0; r < 6; r++) begin
      w = {26'($urandom), $urandom, $urandom};
      run_word(w, 2, r[0], 99);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
